regfile_wb_arbiter: RTL

Write-back arbiter for the 8 x 16-bit register file. It shares the file's single write port between two producers: requester 0 (ALU write-back) and requester 1 (load/memory write-back). Each requester has a one-entry holding slot with a valid/ready handshake. Slots drain oldest-first into a registered write port (wr/wrAddr/wrData). A pending-write mask is exported for RAW stall detection in issue logic.

---
 rtl/regfile_wb_arbiter_pkg.sv | 17 +
 rtl/regfile_wb_arbiter_if.sv | 33 +++
 rtl/regfile_wb_arbiter_slot.sv | 40 ++++
 rtl/regfile_wb_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
package regfile_wb_arbiter_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 16;
    localparam int NREG   = 2 ** ADDR_W;

    localparam int REQ_ALU = 0;
    localparam int REQ_LD  = 1;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Requester handshakes, register-file write port and pending mask.
// The arbiter takes the slave side; producers and the register file the master side.
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              wr;
    logic [ADDR_W-1:0] wrAddr;
    logic [DATA_W-1:0] wrData;
    logic [NREG-1:0]   pending;

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output wr, wrAddr, wrData, pending
    );

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  wr, wrAddr, wrData, pending
    );

endinterface

// File: rtl/regfile_wb_arbiter_slot.sv
// One-entry holding register. A load at the same edge as a clear wins,
// so a slot being drained can be refilled without a bubble.
module wb_slot
    import regfile_wb_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              full_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o
);

    logic              full_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    // Capture on load, empty on clear, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (load_i) begin
            full_q <= 1'b1;
            addr_q <= addr_i;
            data_q <= data_i;
        end else if (clear_i) begin
            full_q <= 1'b0;
        end
    end

    assign full_o = full_q;
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between the ALU and load
// write-back paths. Each path has a one-entry slot; slots drain oldest-first
// into a registered write port.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_arbiter_if.slave   bus
);

    wb_req_t           req [2];
    logic [1:0]        full;
    logic [1:0]        grant;
    logic [1:0]        ready;
    logic [1:0]        accept;
    logic [ADDR_W-1:0] slot_addr [2];
    logic [DATA_W-1:0] slot_data [2];

    logic              old_q, old_d;
    logic              tie_q, tie_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [NREG-1:0]   pending;

    assign req[REQ_ALU] = {bus.req0_valid, bus.req0_addr, bus.req0_data};
    assign req[REQ_LD]  = {bus.req1_valid, bus.req1_addr, bus.req1_data};

    for (genvar k = 0; k < 2; k++) begin : g_slot
        wb_slot u_slot (
            .clk     (clk),
            .rst     (rst),
            .load_i  (accept[k]),
            .clear_i (grant[k]),
            .addr_i  (req[k].addr),
            .data_i  (req[k].data),
            .full_o  (full[k]),
            .addr_o  (slot_addr[k]),
            .data_o  (slot_data[k])
        );
        // Ready depends only on registered state (and rst), never on valid.
        assign ready[k]  = !rst && (!full[k] || grant[k]);
        assign accept[k] = req[k].valid && ready[k];
    end

    // Grant the only full slot, or the older one when both are full.
    always_comb begin
        grant = full;
        if (&full) begin
            grant         = 2'b00;
            grant[old_q]  = 1'b1;
        end
    end

    // Age tracking: the slot that stays full is older than a newly loaded one;
    // simultaneous loads are ordered by the alternating tie pointer.
    always_comb begin
        old_d = old_q;
        tie_d = tie_q;
        if (&accept) begin
            old_d = tie_q;
            tie_d = !tie_q;
        end else if (accept[0] && full[1] && !grant[1]) begin
            old_d = 1'b1;
        end else if (accept[1] && full[0] && !grant[0]) begin
            old_d = 1'b0;
        end
    end

    // Output stage next value: granted slot contents, address/data held when idle.
    always_comb begin
        wr_d      = |grant;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (grant[1]) begin
            wr_addr_d = slot_addr[1];
            wr_data_d = slot_data[1];
        end else if (grant[0]) begin
            wr_addr_d = slot_addr[0];
            wr_data_d = slot_data[0];
        end
    end

    // Arbiter state and registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            old_q     <= 1'b0;
            tie_q     <= 1'b0;
            wr_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            old_q     <= old_d;
            tie_q     <= tie_d;
            wr_q      <= wr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Registers with a write still held in a slot or on the write port.
    always_comb begin
        pending = '0;
        for (int r = 0; r < NREG; r++) begin
            pending[r] = (full[0] && slot_addr[0] == r[ADDR_W-1:0])
                       | (full[1] && slot_addr[1] == r[ADDR_W-1:0])
                       | (wr_q    && wr_addr_q    == r[ADDR_W-1:0]);
        end
    end

    assign bus.req0_ready = ready[0];
    assign bus.req1_ready = ready[1];
    assign bus.wr         = wr_q;
    assign bus.wrAddr     = wr_addr_q;
    assign bus.wrData     = wr_data_q;
    assign bus.pending    = pending;

endmodule
